alu_op_sequencer: RTL and testbench

- Issue stage directly upstream of the 16-bit registered ALU.
- Accepts {A, B, opcode, tag} operations from the decode logic over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the ALU operand/opcode inputs one operation at a time, captures result and flags after the ALU's one-cycle registered latency, and presents them downstream with a valid/ready handshake.
- Exactly one operation is in flight in the ALU at any time.

---
 rtl/alu_op_sequencer_if.sv | 47 ++++
 rtl/alu_op_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle of upstream, ALU-side and downstream signals for the ALU issue stage.
// master = the surrounding logic (decode, ALU, consumer); slave = the sequencer.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
    parameter int NUMBITS = 16,
    parameter int TAGBITS = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] in_A;
    logic [NUMBITS-1:0] in_B;
    logic [2:0]         in_opcode;
    logic [TAGBITS-1:0] in_tag;
    logic [NUMBITS-1:0] alu_A;
    logic [NUMBITS-1:0] alu_B;
    logic [2:0]         alu_opcode;
    logic [NUMBITS-1:0] alu_result;
    logic               alu_carryout;
    logic               alu_overflow;
    logic               alu_zero;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] out_result;
    logic [2:0]         out_flags;
    logic [TAGBITS-1:0] out_tag;
    logic               busy;

    modport master (
        output in_valid, in_A, in_B, in_opcode, in_tag,
        input  in_ready,
        input  alu_A, alu_B, alu_opcode,
        output alu_result, alu_carryout, alu_overflow, alu_zero,
        input  out_valid, out_result, out_flags, out_tag,
        output out_ready,
        input  busy
    );

    modport slave (
        input  in_valid, in_A, in_B, in_opcode, in_tag,
        output in_ready,
        output alu_A, alu_B, alu_opcode,
        input  alu_result, alu_carryout, alu_overflow, alu_zero,
        output out_valid, out_result, out_flags, out_tag,
        input  out_ready,
        output busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the registered 16-bit ALU: buffers operations in a FIFO and
// keeps exactly one in flight, returning result/flags/tag over valid/ready.
`timescale 1ns/1ps
module alu_op_sequencer #(
    parameter int NUMBITS = 16,
    parameter int DEPTH   = 4,
    parameter int TAGBITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // IDLE wait for work | ISSUE load ALU + pop | EXEC ALU registers | CAPTURE sample | OUT hold
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_EXEC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [NUMBITS-1:0] r_fifo_a   [DEPTH];
    logic [NUMBITS-1:0] r_fifo_b   [DEPTH];
    logic [2:0]         r_fifo_op  [DEPTH];
    logic [TAGBITS-1:0] r_fifo_tag [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic [NUMBITS-1:0] r_alu_a;
    logic [NUMBITS-1:0] r_alu_b;
    logic [2:0]         r_alu_op;
    logic [TAGBITS-1:0] r_tag;
    logic               r_out_valid;
    logic [NUMBITS-1:0] r_out_result;
    logic [2:0]         r_out_flags;
    logic [TAGBITS-1:0] r_out_tag;

    logic w_in_ready;
    logic w_push;
    logic w_pop;
    logic w_issue;
    logic w_capture;
    logic w_done;
    logic w_busy;

    assign w_in_ready = (r_count != FULL);
    assign w_push     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (r_count != '0) w_next = S_ISSUE;
            S_ISSUE:   w_next = S_EXEC;
            S_EXEC:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_OUT;
            S_OUT:     if (r_out_valid && bus.out_ready)
                           w_next = (r_count != '0) ? S_ISSUE : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = (r_state == S_ISSUE);
        w_capture = (r_state == S_CAPTURE);
        w_done    = (r_state == S_OUT) && r_out_valid && bus.out_ready;
        w_pop     = w_issue;
        w_busy    = (r_state != S_IDLE) || (r_count != '0);
    end

    // Storage needs no reset: count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wr_ptr]   <= bus.in_A;
            r_fifo_b[r_wr_ptr]   <= bus.in_B;
            r_fifo_op[r_wr_ptr]  <= bus.in_opcode;
            r_fifo_tag[r_wr_ptr] <= bus.in_tag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_tag        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_tag    <= '0;
        end else begin
            if (w_issue) begin
                r_alu_a  <= r_fifo_a[r_rd_ptr];
                r_alu_b  <= r_fifo_b[r_rd_ptr];
                r_alu_op <= r_fifo_op[r_rd_ptr];
                r_tag    <= r_fifo_tag[r_rd_ptr];
            end
            if (w_capture) begin
                r_out_result <= bus.alu_result;
                r_out_flags  <= {bus.alu_carryout, bus.alu_overflow, bus.alu_zero};
                r_out_tag    <= r_tag;
                r_out_valid  <= 1'b1;
            end else if (w_done) begin
                r_out_valid  <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.alu_A      = r_alu_a;
    assign bus.alu_B      = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_flags  = r_out_flags;
    assign bus.out_tag    = r_out_tag;
    assign bus.busy       = w_busy;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-cycle registered ALU.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_op_sequencer_if #(.NUMBITS(16), .TAGBITS(4)) intf ();

    alu_op_sequencer #(.NUMBITS(16), .DEPTH(4), .TAGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes: 000/001 add, 010 sub, 011 slt, 100 and, 101 nand, 110 xor, 111 or.
    function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        logic        v;
        s = 17'd0;
        r = 16'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000, 3'b001: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'b010: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'b011:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            3'b100:  r = a & b;
            3'b101:  r = ~(a & b);
            3'b110:  r = a ^ b;
            default: r = a | b;
        endcase
        return {c, v, (r == 16'd0), r};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset)
            {intf.alu_carryout, intf.alu_overflow, intf.alu_zero, intf.alu_result} <= 19'd0;
        else
            {intf.alu_carryout, intf.alu_overflow, intf.alu_zero, intf.alu_result} <=
                alu_model(intf.alu_A, intf.alu_B, intf.alu_opcode);
    end

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [2:0] op, input logic [3:0] tag);
        intf.in_valid  = 1'b1;
        intf.in_A      = a;
        intf.in_B      = b;
        intf.in_opcode = op;
        intf.in_tag    = tag;
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [3:0] tag);
        drive_op(a, b, op, tag);
        @(negedge clk);
        intf.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            if (intf.out_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        intf.in_valid = 1'b0;
        intf.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (intf.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", intf.out_valid); end
        total++;
        if ({intf.alu_A, intf.alu_B, intf.alu_opcode} !== 35'd0) begin
            bad++; $display("FAIL reset_alu got=%h/%h/%b exp=0", intf.alu_A, intf.alu_B, intf.alu_opcode);
        end
        total++;
        if ({intf.out_result, intf.out_flags, intf.out_tag} !== 23'd0) begin
            bad++; $display("FAIL reset_out got=%h/%b/%h exp=0", intf.out_result, intf.out_flags, intf.out_tag);
        end
        total++;
        if (intf.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", intf.busy); end
        total++;
        if (intf.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", intf.in_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency;
        logic exp_v;
        intf.out_ready = 1'b1;
        drive_op(16'hFFFF, 16'h0001, 3'b000, 4'd3);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) intf.in_valid = 1'b0;
            exp_v = (i == 5);
            total++;
            if (intf.out_valid !== exp_v) begin
                bad++; $display("FAIL latency_valid edge=%0d got=%b exp=%b", i, intf.out_valid, exp_v);
            end
            if (i == 3) begin
                total++;
                if ({intf.alu_A, intf.alu_B, intf.alu_opcode} !== {16'hFFFF, 16'h0001, 3'b000}) begin
                    bad++; $display("FAIL latency_alu_in got=%h/%h/%b exp=ffff/0001/000",
                                    intf.alu_A, intf.alu_B, intf.alu_opcode);
                end
            end
        end
        total++;
        if ({intf.out_result, intf.out_flags, intf.out_tag} !== {16'h0000, 3'b101, 4'd3}) begin
            bad++; $display("FAIL latency_result got=%h/%b/%h exp=0000/101/3",
                            intf.out_result, intf.out_flags, intf.out_tag);
        end
        @(negedge clk);
        total++;
        if ({intf.out_valid, intf.busy} !== 2'b00) begin
            bad++; $display("FAIL latency_drain got valid/busy=%b%b exp=00", intf.out_valid, intf.busy);
        end
    endtask

    task automatic test_fill;
        logic [15:0] va   [5];
        logic [15:0] vb   [5];
        logic [2:0]  vop  [5];
        logic [3:0]  vtag [5];
        logic [15:0] er   [5];
        logic [2:0]  ef   [5];
        bit got;
        va   = '{16'h0001, 16'h1234, 16'hAAAA, 16'h8000, 16'h00F0};
        vb   = '{16'h0002, 16'h00FF, 16'hAAAA, 16'h8000, 16'h0F00};
        vop  = '{3'b000, 3'b100, 3'b110, 3'b000, 3'b110};
        vtag = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
        er   = '{16'h0003, 16'h0034, 16'h0000, 16'h0000, 16'h0FF0};
        ef   = '{3'b000, 3'b000, 3'b001, 3'b111, 3'b000};
        intf.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(va[i], vb[i], vop[i], vtag[i]);
        total++;
        if (intf.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b exp=0", intf.in_ready); end
        total++;
        if ({intf.out_valid, intf.out_tag} !== {1'b1, 4'd1}) begin
            bad++; $display("FAIL fill_held got valid=%b tag=%h exp valid=1 tag=1", intf.out_valid, intf.out_tag);
        end
        drive_op(16'h0007, 16'h0007, 3'b000, 4'd7);
        repeat (3) @(negedge clk);
        total++;
        if ({intf.in_ready, intf.out_tag} !== {1'b0, 4'd1}) begin
            bad++; $display("FAIL fill_sixth got ready=%b tag=%h exp ready=0 tag=1", intf.in_ready, intf.out_tag);
        end
        intf.in_valid = 1'b0;
        intf.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(20, got);
            total++;
            if (got !== 1'b1) begin bad++; $display("FAIL fill_timeout idx=%0d got=0 exp=1", i); end
            total++;
            if ({intf.out_result, intf.out_flags, intf.out_tag} !== {er[i], ef[i], vtag[i]}) begin
                bad++; $display("FAIL fill_result idx=%0d got=%h/%b/%h exp=%h/%b/%h", i,
                                intf.out_result, intf.out_flags, intf.out_tag, er[i], ef[i], vtag[i]);
            end
            @(negedge clk);
        end
        total++;
        if ({intf.busy, intf.in_ready} !== 2'b01) begin
            bad++; $display("FAIL fill_drain got busy/ready=%b%b exp=01", intf.busy, intf.in_ready);
        end
    endtask

    task automatic test_signed_add;
        bit got;
        intf.out_ready = 1'b1;
        push_op(16'h7FFF, 16'h0001, 3'b001, 4'd9);
        wait_valid(10, got);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL sadd_timeout got=0 exp=1"); end
        total++;
        if ({intf.out_result, intf.out_flags, intf.out_tag} !== {16'h8000, 3'b010, 4'd9}) begin
            bad++; $display("FAIL sadd_result got=%h/%b/%h exp=8000/010/9",
                            intf.out_result, intf.out_flags, intf.out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_logic;
        logic [15:0] er [2];
        logic [2:0]  ef [2];
        logic [3:0]  et [2];
        bit got;
        er = '{16'h0000, 16'hFFFF};
        ef = '{3'b001, 3'b000};
        et = '{4'hA, 4'hB};
        intf.out_ready = 1'b1;
        push_op(16'hF0F0, 16'h0F0F, 3'b100, 4'hA);
        push_op(16'hAAAA, 16'h5555, 3'b110, 4'hB);
        for (int i = 0; i < 2; i++) begin
            wait_valid(12, got);
            total++;
            if (got !== 1'b1) begin bad++; $display("FAIL logic_timeout idx=%0d got=0 exp=1", i); end
            total++;
            if ({intf.out_result, intf.out_flags, intf.out_tag} !== {er[i], ef[i], et[i]}) begin
                bad++; $display("FAIL logic_result idx=%0d got=%h/%b/%h exp=%h/%b/%h", i,
                                intf.out_result, intf.out_flags, intf.out_tag, er[i], ef[i], et[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        intf.out_ready = 1'b0;
        push_op(16'h1234, 16'h1111, 3'b000, 4'd1);
        push_op(16'h2222, 16'h3333, 3'b000, 4'd2);
        push_op(16'h4444, 16'h5555, 3'b000, 4'd3);
        total++;
        if ({intf.alu_A, intf.busy} !== {16'h1234, 1'b1}) begin
            bad++; $display("FAIL rstmid_pre got alu_A=%h busy=%b exp 1234/1", intf.alu_A, intf.busy);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({intf.alu_A, intf.alu_B, intf.alu_opcode} !== 35'd0) begin
            bad++; $display("FAIL rstmid_alu got=%h/%h/%b exp=0", intf.alu_A, intf.alu_B, intf.alu_opcode);
        end
        total++;
        if ({intf.out_valid, intf.busy, intf.in_ready} !== 3'b001) begin
            bad++; $display("FAIL rstmid_ctrl got valid/busy/ready=%b%b%b exp=001",
                            intf.out_valid, intf.busy, intf.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        intf.out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (intf.out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rstmid_stale got=%0d results exp=0", seen); end
        total++;
        if (intf.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", intf.busy); end
    endtask

    task automatic test_push_on_handshake;
        logic exp_v;
        bit got;
        intf.out_ready = 1'b0;
        push_op(16'h0005, 16'h0003, 3'b000, 4'hC);
        wait_valid(10, got);
        total++;
        if (got !== 1'b1) begin bad++; $display("FAIL hs_timeout got=0 exp=1"); end
        total++;
        if ({intf.out_result, intf.out_flags, intf.out_tag} !== {16'h0008, 3'b000, 4'hC}) begin
            bad++; $display("FAIL hs_first got=%h/%b/%h exp=0008/000/c",
                            intf.out_result, intf.out_flags, intf.out_tag);
        end
        intf.out_ready = 1'b1;
        drive_op(16'hFFFF, 16'h00FF, 3'b110, 4'hD);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) intf.in_valid = 1'b0;
            exp_v = (i == 5);
            total++;
            if (intf.out_valid !== exp_v) begin
                bad++; $display("FAIL hs_valid edge=%0d got=%b exp=%b", i, intf.out_valid, exp_v);
            end
        end
        total++;
        if ({intf.out_result, intf.out_flags, intf.out_tag} !== {16'hFF00, 3'b000, 4'hD}) begin
            bad++; $display("FAIL hs_second got=%h/%b/%h exp=ff00/000/d",
                            intf.out_result, intf.out_flags, intf.out_tag);
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        intf.in_valid = 1'b0;
        intf.in_A = 16'd0;
        intf.in_B = 16'd0;
        intf.in_opcode = 3'd0;
        intf.in_tag = 4'd0;
        intf.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_fill();
        test_signed_add();
        test_logic();
        test_reset_mid();
        test_push_on_handshake();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
